// File: rtl/bf_phase_sequencer.sv
// ============================================================================
//  Module      : bf_phase_sequencer
//  Description : Single-clock Brainfuck execution controller issuing one-cycle
//                read / decode / write enables with run, step and halt control.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module bf_phase_sequencer #(
    parameter int TICK_DIV = 50_000,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             step,
    input  logic             halt_req,
    input  logic             rom_overrun,
    input  logic             cout,
    input  logic             sfr_busy,
    output logic             ram_rd_en,
    output logic             core_en,
    output logic             ram_wr_en,
    output logic             sfr_wr,
    output logic [1:0]       phase,
    output logic             running,
    output logic             done,
    output logic [CNT_W-1:0] retired
);

    localparam int                 c_PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(TICK_DIV - 1);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_READ     = 3'd1;
    localparam logic [2:0] c_DECODE   = 3'd2;
    localparam logic [2:0] c_WRITE    = 3'd3;
    localparam logic [2:0] c_WAIT_SFR = 3'd4;
    localparam logic [2:0] c_DONE     = 3'd5;

    logic [c_PRE_W-1:0] r_presc;
    logic [2:0]         r_state;
    logic               r_single;
    logic               r_rd;
    logic               r_core;
    logic               r_wr;
    logic               r_sfr;
    logic [CNT_W-1:0]   r_retired;

    logic               w_tick;
    logic               w_commit;
    logic               w_commit_sfr;
    logic               w_continue;

    assign w_tick = (r_presc == c_PRE_MAX);

    // A write completes either on a WRITE tick with the SFR free, or on the
    // first non-busy cycle of WAIT_SFR (which does not wait for a tick).
    assign w_commit     = ((r_state == c_WRITE) && w_tick && !(cout && sfr_busy)) ||
                          ((r_state == c_WAIT_SFR) && !sfr_busy);
    assign w_commit_sfr = (r_state == c_WAIT_SFR) || cout;
    assign w_continue   = run && !halt_req && !r_single;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc   <= '0;
            r_state   <= c_IDLE;
            r_single  <= 1'b0;
            r_rd      <= 1'b0;
            r_core    <= 1'b0;
            r_wr      <= 1'b0;
            r_sfr     <= 1'b0;
            r_retired <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            r_rd    <= 1'b0;
            r_core  <= 1'b0;
            r_wr    <= 1'b0;
            r_sfr   <= 1'b0;

            if (w_commit) begin
                r_wr      <= 1'b1;
                r_sfr     <= w_commit_sfr;
                r_retired <= r_retired + 1'b1;
                r_state   <= w_continue ? c_READ : c_IDLE;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        if (!halt_req && (run || step)) begin
                            r_state  <= c_READ;
                            r_single <= !run;
                        end
                    end
                    c_READ: begin
                        if (w_tick) begin
                            if (rom_overrun) begin
                                r_state <= c_DONE;
                            end else begin
                                r_rd    <= 1'b1;
                                r_state <= c_DECODE;
                            end
                        end
                    end
                    c_DECODE: begin
                        if (w_tick) begin
                            r_core  <= 1'b1;
                            r_state <= c_WRITE;
                        end
                    end
                    c_WRITE: begin
                        if (w_tick) begin
                            r_state <= c_WAIT_SFR;
                        end
                    end
                    c_WAIT_SFR: begin
                        r_state <= c_WAIT_SFR;
                    end
                    c_DONE: begin
                        r_state <= c_DONE;
                    end
                    default: begin
                        r_state <= c_IDLE;
                    end
                endcase
            end
        end
    end

    always_comb begin
        phase = 2'd0;
        case (r_state)
            c_READ:     phase = 2'd1;
            c_DECODE:   phase = 2'd2;
            c_WRITE:    phase = 2'd3;
            c_WAIT_SFR: phase = 2'd3;
            default:    phase = 2'd0;
        endcase
    end

    assign running   = (r_state == c_READ) || (r_state == c_DECODE) ||
                       (r_state == c_WRITE) || (r_state == c_WAIT_SFR);
    assign done      = (r_state == c_DONE);
    assign ram_rd_en = r_rd;
    assign core_en   = r_core;
    assign ram_wr_en = r_wr;
    assign sfr_wr    = r_sfr;
    assign retired   = r_retired;

endmodule

`default_nettype wire
